data_bus_responder: RTL and testbench

Responder for the CPU's Harvard data port: serves `data_read`/`data_write` requests from an internal word-addressed RAM and paces the CPU by driving its `clk_enable`. It inserts a configurable number of wait states per access, so the pipelined core can be run against slow memory in simulation and on FPGA. It sits between `mips_cpu` (data port plus `clk_enable`) and the testbench or top level. The instruction port is not served by this block.

---
 rtl/mips_bus_pkg.sv | 6 +
 rtl/data_memory_array.sv | 24 ++
 rtl/data_bus_responder.sv | 118 +++++++++++
 tb/tb_data_bus_responder.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/mips_bus_pkg.sv
// Shared types and constants for the CPU data-port responder.
package mips_bus_pkg;
    typedef enum logic [1:0] {IDLE, BUSY, GRANT} bus_state_t;
    localparam logic [31:0] BUS_ERROR_READ_VALUE = 32'h0;
    localparam int WAIT_COUNTER_WIDTH = 4;
endpackage

// File: rtl/data_memory_array.sv
// Word RAM, one synchronous write port and one synchronous read port; no reset.
// Read data appears the cycle after rd_en; write and read are independent.
module data_memory_array #(
    parameter int ADDR_BITS = 10
) (
    input  logic                 clk,
    input  logic                 wr_en,
    input  logic [ADDR_BITS-1:0] wr_addr,
    input  logic [31:0]          wr_data,
    input  logic                 rd_en,
    input  logic [ADDR_BITS-1:0] rd_addr,
    output logic [31:0]          rd_data
);
    logic [31:0] mem [0:(1<<ADDR_BITS)-1];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end
endmodule

// File: rtl/data_bus_responder.sv
// CPU data-port responder: WAIT_STATES+3 cycles per access, 2 per idle cycle.
// The CPU is paced solely through clk_enable; it is frozen while clk_enable is low.
module data_bus_responder
    import mips_bus_pkg::*;
#(
    parameter int          ADDR_BITS   = 10,
    parameter int          WAIT_STATES = 2,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] data_address,
    input  logic        data_write,
    input  logic        data_read,
    input  logic [31:0] data_writedata,
    output logic [31:0] data_readdata,
    output logic        clk_enable,
    output logic        bus_error,
    output logic [31:0] access_count
);
    localparam logic [WAIT_COUNTER_WIDTH-1:0] WAIT_LOAD = WAIT_COUNTER_WIDTH'(WAIT_STATES);

    bus_state_t                    state;
    logic [WAIT_COUNTER_WIDTH-1:0] cnt;
    logic                          lat_wr;
    logic                          lat_fault;
    logic [ADDR_BITS-1:0]          lat_idx;
    logic [31:0]                   lat_wdata;

    logic [31:0]          off;
    logic [ADDR_BITS-1:0] idx_now;
    logic                 fault_now;
    logic                 req;
    logic                 access_now;
    logic                 mem_wr_en;
    logic                 mem_rd_en;
    logic [31:0]          mem_rdata;

    assign off        = data_address - BASE_ADDR;
    assign idx_now    = off[ADDR_BITS+1:2];
    assign fault_now  = (off[1:0] != 2'b00) || ((off >> (ADDR_BITS + 2)) != 32'd0);
    assign req        = data_read | data_write;
    assign access_now = (state == BUSY) && (cnt == '0);
    assign mem_wr_en  = access_now && lat_wr && !lat_fault;
    // Read is launched as the request is accepted so the word is ready by the
    // final BUSY edge even with zero wait states.
    assign mem_rd_en  = (state == IDLE) && req;

    data_memory_array #(
        .ADDR_BITS(ADDR_BITS)
    ) u_mem (
        .clk    (clk),
        .wr_en  (mem_wr_en),
        .wr_addr(lat_idx),
        .wr_data(lat_wdata),
        .rd_en  (mem_rd_en),
        .rd_addr(idx_now),
        .rd_data(mem_rdata)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            cnt           <= '0;
            lat_wr        <= 1'b0;
            lat_fault     <= 1'b0;
            lat_idx       <= '0;
            lat_wdata     <= '0;
            clk_enable    <= 1'b0;
            data_readdata <= '0;
            bus_error     <= 1'b0;
            access_count  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req) begin
                        lat_wr     <= data_write;
                        lat_fault  <= fault_now;
                        lat_idx    <= idx_now;
                        lat_wdata  <= data_writedata;
                        cnt        <= WAIT_LOAD;
                        clk_enable <= 1'b0;
                        state      <= BUSY;
                    end else begin
                        data_readdata <= '0;
                        clk_enable    <= 1'b1;
                        state         <= GRANT;
                    end
                end
                BUSY: begin
                    if (cnt == '0) begin
                        if (lat_fault) begin
                            data_readdata <= BUS_ERROR_READ_VALUE;
                            bus_error     <= 1'b1;
                        end else if (lat_wr) begin
                            data_readdata <= '0;
                        end else begin
                            data_readdata <= mem_rdata;
                        end
                        access_count <= access_count + 32'd1;
                        clk_enable   <= 1'b1;
                        state        <= GRANT;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                GRANT: begin
                    clk_enable <= 1'b0;
                    state      <= IDLE;
                end
                default: begin
                    clk_enable <= 1'b0;
                    state      <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_data_bus_responder.sv
// Randomized bench for data_bus_responder against an address-map/latency reference model.
module tb_data_bus_responder;
    logic        clk = 1'b0;
    logic        rst     [3];
    logic [31:0] d_addr  [3];
    logic        d_wr    [3];
    logic        d_rd    [3];
    logic [31:0] d_wdata [3];
    logic [31:0] d_rdata [3];
    logic        ce      [3];
    logic        berr    [3];
    logic [31:0] acnt    [3];

    int total = 0;
    int bad = 0;

    logic [31:0] mmem [int];
    logic        exp_err [3];
    logic [31:0] exp_cnt [3];

    always #5 clk = ~clk;

    data_bus_responder #(.ADDR_BITS(10), .WAIT_STATES(2), .BASE_ADDR(32'h0000_0000)) u_dut0 (
        .clk(clk), .reset(rst[0]), .data_address(d_addr[0]), .data_write(d_wr[0]),
        .data_read(d_rd[0]), .data_writedata(d_wdata[0]), .data_readdata(d_rdata[0]),
        .clk_enable(ce[0]), .bus_error(berr[0]), .access_count(acnt[0]));

    data_bus_responder #(.ADDR_BITS(4), .WAIT_STATES(1), .BASE_ADDR(32'h1000_0000)) u_dut1 (
        .clk(clk), .reset(rst[1]), .data_address(d_addr[1]), .data_write(d_wr[1]),
        .data_read(d_rd[1]), .data_writedata(d_wdata[1]), .data_readdata(d_rdata[1]),
        .clk_enable(ce[1]), .bus_error(berr[1]), .access_count(acnt[1]));

    data_bus_responder #(.ADDR_BITS(10), .WAIT_STATES(0), .BASE_ADDR(32'h0000_0000)) u_dut2 (
        .clk(clk), .reset(rst[2]), .data_address(d_addr[2]), .data_write(d_wr[2]),
        .data_read(d_rd[2]), .data_writedata(d_wdata[2]), .data_readdata(d_rdata[2]),
        .clk_enable(ce[2]), .bus_error(berr[2]), .access_count(acnt[2]));

    function automatic int ws_of(input int k);
        case (k)
            0: return 2;
            1: return 1;
            default: return 0;
        endcase
    endfunction

    function automatic int ab_of(input int k);
        return (k == 1) ? 4 : 10;
    endfunction

    function automatic logic [31:0] base_of(input int k);
        return (k == 1) ? 32'h1000_0000 : 32'h0000_0000;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Waits for a clk_enable pulse and returns just after the CPU consumes it.
    task automatic sync_pulse(input int k);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (ce[k] !== 1'b1 && n < 40);
        check_eq("sync_pulse_seen", {31'd0, ce[k]}, 32'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic do_access(input int k, input bit rd, input bit wr,
                             input logic [31:0] a, input logic [31:0] wd,
                             output logic [31:0] got);
        int          n;
        logic [31:0] off;
        logic [31:0] exp_data;
        bit          flt;
        bit          known;
        int          key;

        sync_pulse(k);
        d_rd[k]    = rd;
        d_wr[k]    = wr;
        d_addr[k]  = a;
        d_wdata[k] = wd;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (ce[k] !== 1'b1 && n < 40);
        check_eq("latency", n, ws_of(k) + 3);

        off   = a - base_of(k);
        flt   = (off % 4 != 0) || (off >= (32'd4 << ab_of(k)));
        key   = k * 4096 + int'(off / 4);
        known = 1'b1;
        if (flt || wr) begin
            exp_data = 32'h0;
        end else if (mmem.exists(key)) begin
            exp_data = mmem[key];
        end else begin
            exp_data = 32'h0;
            known    = 1'b0;
        end
        if (!flt && wr) mmem[key] = wd;
        exp_cnt[k] = exp_cnt[k] + 32'd1;
        exp_err[k] = exp_err[k] | flt;

        got = d_rdata[k];
        if (known) check_eq("readdata", d_rdata[k], exp_data);
        check_eq("bus_error", {31'd0, berr[k]}, {31'd0, exp_err[k]});
        check_eq("access_count", acnt[k], exp_cnt[k]);

        @(posedge clk);
        #1;
        d_rd[k]    = 1'b0;
        d_wr[k]    = 1'b0;
        d_addr[k]  = $urandom;
        d_wdata[k] = $urandom;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] got;
        int          r;
        int          op;
        logic [31:0] a;

        for (int k = 0; k < 3; k++) begin
            rst[k] = 1'b1; d_addr[k] = '0; d_wr[k] = 1'b0; d_rd[k] = 1'b0; d_wdata[k] = '0;
            exp_err[k] = 1'b0; exp_cnt[k] = '0;
        end
        repeat (2) @(negedge clk);
        for (int k = 0; k < 3; k++) rst[k] = 1'b0;
        for (int k = 0; k < 3; k++) begin
            check_eq("rst_ce", {31'd0, ce[k]}, 32'd0);
            check_eq("rst_data", d_rdata[k], 32'd0);
            check_eq("rst_err", {31'd0, berr[k]}, 32'd0);
            check_eq("rst_cnt", acnt[k], 32'd0);
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check_eq("idle_ce", {31'd0, ce[0]}, (i % 2 == 0) ? 32'd1 : 32'd0);
            check_eq("idle_ce_ws0", {31'd0, ce[2]}, (i % 2 == 0) ? 32'd1 : 32'd0);
            check_eq("idle_cnt", acnt[0], 32'd0);
        end

        // Write then read back the same word.
        do_access(0, 1'b0, 1'b1, 32'h10, 32'hCAFE_F00D, got);
        do_access(0, 1'b1, 1'b0, 32'h10, 32'h0, got);
        check_eq("raw_data", got, 32'hCAFE_F00D);
        check_eq("raw_cnt", acnt[0], 32'd2);

        // Reset in the middle of a write's wait states abandons it.
        do_access(0, 1'b0, 1'b1, 32'h20, 32'h1111_2222, got);
        sync_pulse(0);
        d_wr[0] = 1'b1; d_addr[0] = 32'h20; d_wdata[0] = 32'hDEAD_BEEF;
        repeat (2) @(negedge clk);
        rst[0] = 1'b1;
        d_wr[0] = 1'b0;
        @(negedge clk);
        check_eq("midbusy_rst_ce", {31'd0, ce[0]}, 32'd0);
        rst[0] = 1'b0;
        exp_cnt[0] = '0;
        exp_err[0] = 1'b0;
        mmem[0 * 4096 + 8] = 32'h1111_2222;
        do_access(0, 1'b1, 1'b0, 32'h20, 32'h0, got);
        check_eq("abort_data", got, 32'h1111_2222);
        check_eq("abort_cnt", acnt[0], 32'd1);

        // Misaligned accesses fault and leave RAM untouched.
        do_access(0, 1'b1, 1'b0, 32'h13, 32'h0, got);
        check_eq("misalign_data", got, 32'h0);
        check_eq("misalign_err", {31'd0, berr[0]}, 32'd1);
        do_access(0, 1'b0, 1'b1, 32'h11, 32'hBAD0_BAD0, got);
        do_access(0, 1'b1, 1'b0, 32'h10, 32'h0, got);
        check_eq("after_fault_data", got, 32'hCAFE_F00D);
        check_eq("sticky_err", {31'd0, berr[0]}, 32'd1);

        // Offset base, 16-word RAM: range checking and wrap-around.
        do_access(1, 1'b0, 1'b1, 32'h1000_0000, 32'hA0A0_A0A0, got);
        do_access(1, 1'b0, 1'b1, 32'h1000_0040, 32'h5555_5555, got);
        check_eq("oor_err", {31'd0, berr[1]}, 32'd1);
        do_access(1, 1'b1, 1'b0, 32'h1000_0000, 32'h0, got);
        check_eq("oor_no_alias", got, 32'hA0A0_A0A0);
        do_access(1, 1'b0, 1'b1, 32'h1000_003C, 32'h0F0F_0F0F, got);
        do_access(1, 1'b1, 1'b0, 32'h1000_003C, 32'h0, got);
        check_eq("top_word", got, 32'h0F0F_0F0F);
        do_access(1, 1'b0, 1'b1, 32'h0FFF_FFFC, 32'h7777_7777, got);
        check_eq("below_base_cnt", acnt[1], 32'd6);

        // Zero wait states; write wins when both request lines are high.
        do_access(2, 1'b1, 1'b1, 32'h40, 32'h1234_5678, got);
        check_eq("both_data", got, 32'h0);
        do_access(2, 1'b1, 1'b0, 32'h40, 32'h0, got);
        check_eq("both_written", got, 32'h1234_5678);

        // Randomized traffic over a 16-word window per instance.
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < 16; i++) begin
                do_access(k, 1'b0, 1'b1, base_of(k) + 32'(i * 4), $urandom, got);
            end
            for (int i = 0; i < 30; i++) begin
                r  = $urandom_range(0, 9);
                op = $urandom_range(0, 3);
                a  = base_of(k) + 32'($urandom_range(0, 15) * 4);
                if (r == 0) a = a + 32'($urandom_range(1, 3));
                else if (r == 1) a = a + (32'd4 << ab_of(k));
                do_access(k, op != 2, op >= 2, a, $urandom, got);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
